// File: rtl/synth_mux_pkg.sv
// rtl/synth_mux_pkg.sv - shared types and defaults for the synth output voice mux
package synth_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } xfade_state_t;

  localparam int DW_DEF = 16;
  localparam int N_DEF  = 8;

endpackage

// File: rtl/onehot_to_index.sv
// rtl/onehot_to_index.sv - one-hot to binary index encoder with exactly-one-set flag
module onehot_to_index #(
  parameter int N = 8
) (
  input  logic [N-1:0]         onehot_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;

  // OR together the indices of set bits and count them; index is only meaningful when valid
  always_comb begin
    idx_o = '0;
    cnt   = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot_i[i]) begin
        idx_o = idx_o | IW'(i);
        cnt   = cnt + 1'b1;
      end
    end
    valid_o = (cnt == CW'(1));
  end

endmodule

// File: rtl/voice_xfade_mux.sv
// rtl/voice_xfade_mux.sv - one-hot voice selector with linear crossfade; VOICE_XFADE_MUX_ONEHOT_CHECK_EN adds onehot_err
module voice_xfade_mux
  import synth_mux_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int DW        = DW_DEF,
  parameter int RAMP_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_en,
  input  logic [N-1:0]         sel_onehot,
  input  logic signed [DW-1:0] data_in [N],
  output logic signed [DW-1:0] data_out,
  output logic [$clog2(N)-1:0] sel_index,
  output logic                 busy
`ifdef VOICE_XFADE_MUX_ONEHOT_CHECK_EN
  ,
  output logic                 onehot_err
`endif
);

  localparam int IW = $clog2(N);
  localparam int AW = DW + RAMP_LOG2 + 1;
  localparam logic [RAMP_LOG2:0] R_W = (RAMP_LOG2 + 1)'(1) << RAMP_LOG2;

  xfade_state_t          state_q, state_d;
  logic [IW-1:0]         cur_q, cur_d;
  logic [IW-1:0]         tgt_q, tgt_d;
  logic [IW-1:0]         pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [RAMP_LOG2:0]    k_q, k_d;
  logic signed [DW-1:0]  data_q, data_d;

  logic [IW-1:0]         sel_idx;
  logic                  sel_vld;

  onehot_to_index #(.N(N)) u_sel_enc (
    .onehot_i (sel_onehot),
    .idx_o    (sel_idx),
    .valid_o  (sel_vld)
  );

  // Mixing datapath: weight w = k+1 on the target, R-w on the source; the sum is a
  // convex combination scaled by R, so it always fits AW bits and the floor shift
  // brings it back into DW range without saturation.
  logic [RAMP_LOG2:0]    w_new, w_old;
  logic signed [AW-1:0]  s_cur, s_tgt, mix, mix_sh;
  logic                  unused_mix_bits;

  assign w_new  = k_q + 1'b1;
  assign w_old  = R_W - w_new;
  assign s_cur  = {{(AW-DW){data_in[cur_q][DW-1]}}, data_in[cur_q]};
  assign s_tgt  = {{(AW-DW){data_in[tgt_q][DW-1]}}, data_in[tgt_q]};
  assign mix    = s_cur * $signed({{DW{1'b0}}, w_old}) + s_tgt * $signed({{DW{1'b0}}, w_new});
  assign mix_sh = mix >>> RAMP_LOG2;
  assign unused_mix_bits = ^mix_sh[AW-1:DW];

  // State register: async reset abandons any fade and returns to channel 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      tgt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      k_q        <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      k_q        <= k_d;
      data_q     <= data_d;
    end
  end

  // Next state: IDLE passes the committed channel through and launches fades from a
  // fresh select or a request left pending at the end of the previous fade; FADE
  // ramps one step per strobe and only queues new requests, never interrupts.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    k_d        = k_q;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        if (sample_en) begin
          data_d = data_in[cur_q];
        end
        if (sel_vld) begin
          pend_vld_d = 1'b0;
          if (sel_idx != cur_q) begin
            tgt_d   = sel_idx;
            k_d     = '0;
            state_d = FADE;
          end
        end else if (pend_vld_q) begin
          pend_vld_d = 1'b0;
          if (pend_q != cur_q) begin
            tgt_d   = pend_q;
            k_d     = '0;
            state_d = FADE;
          end
        end
      end
      FADE: begin
        if (sel_vld) begin
          if (sel_idx == tgt_q) begin
            pend_vld_d = 1'b0;
          end else begin
            pend_d     = sel_idx;
            pend_vld_d = 1'b1;
          end
        end
        if (sample_en) begin
          data_d = mix_sh[DW-1:0];
          k_d    = k_q + 1'b1;
          if (w_new == R_W) begin
            cur_d   = tgt_q;
            k_d     = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from registers
  always_comb begin
    data_out  = data_q;
    sel_index = cur_q;
    busy      = (state_q == FADE);
  end

`ifdef VOICE_XFADE_MUX_ONEHOT_CHECK_EN
  logic err_q;

  // Flag any clk whose select was not exactly one-hot, one clk later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= ~sel_vld;
    end
  end

  assign onehot_err = err_q;
`endif

endmodule

// File: doc/voice_xfade_mux.md
Name: voice_xfade_mux

Overview:
- Parametrised successor to the 8×16 one-hot voice selector in the synth output path.
- Selects one of N signed DW-bit channels using a one-hot select.
- On a selection change it crossfades linearly from the old channel to the new one over 2^RAMP_LOG2 sample strobes, so there is no step-change click.
- Output is registered and updates only on sample_en; the block sits between the voice bank and the DAC/I2S feeder.

Parameters:
- N, 8: number of input channels (N ≥ 2).
- DW, 16: sample width, signed two's complement.
- RAMP_LOG2, 4: crossfade length R = 2^RAMP_LOG2 strobes (0 = instant switch on the next strobe).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sample_en  in  1  one-clk sample strobe; all output updates occur only on it.
- sel_onehot  in  N  requested channel, one-hot.
- data_in  in  DW×N (unpacked [N])  channel samples, signed.
- data_out  out  DW  registered mixed sample, signed.
- sel_index  out  $clog2(N)  committed source index.
- busy  out  1  crossfade in progress.
- onehot_err  out  1  present only with the optional feature.

Behaviour:
- Reset (async assert, sync release): data_out=0, sel_index=0, busy=0, state=IDLE, k=0, pending cleared.
- Select validity: sel_onehot is valid only when exactly one bit is set. Zero or multi-hot is ignored: selection held, no fade.
- Internal registers: cur_idx (drives sel_index), tgt_idx, pending_idx plus valid bit, weight counter k (RAMP_LOG2+1 bits).
- IDLE:
  - On sample_en: data_out <= data_in[cur_idx] (1-clk latency).
  - Valid select with idx == cur_idx: no action.
  - Valid select with idx != cur_idx: next clk tgt_idx<=idx, k<=0, state<=FADE, busy<=1.
- FADE:
  - On each sample_en: w = k+1; data_out <= (data_in[cur]*(R−w) + data_in[tgt]*w) >>> RAMP_LOG2; k<=k+1.
  - Intermediate width is DW+RAMP_LOG2+1 signed. The shift is arithmetic (floor). No saturation is needed because the result is a convex combination.
  - On the strobe where w == R: data_out = data_in[tgt] exactly; cur_idx<=tgt_idx; busy<=0.
  - Then, if pending is valid and != the new cur_idx, enter FADE to pending_idx on the next clk (busy re-asserts that clk). Otherwise go to IDLE. Pending is cleared in both cases.
  - Valid select arriving mid-fade: if idx == tgt_idx, pending is cleared; otherwise pending_idx<=idx (last valid request wins). The current fade is never interrupted.
- Simultaneous events:
  - A select change on the same clk as sample_en in IDLE: the strobe outputs data_in[cur_idx]; the fade starts next clk.
  - A select on the same clk as the final fade strobe is treated as pending.
- Without sample_en the state and k never advance; a fade can stall indefinitely.
- Reset mid-fade: immediate return to the reset values; the fade is abandoned.

Optional Feature:
- Macro: VOICE_XFADE_MUX_ONEHOT_CHECK_EN.
- Defined: onehot_err port exists, registered. It is 1 on the clk after any clk where sel_onehot is not exactly one-hot (including all-zero), else 0. Reset value 0.
- Undefined: port and logic absent. Invalid-select ignore behaviour is identical.

Decomposition:
- Package synth_mux_pkg: xfade_state_t enum {IDLE, FADE}; localparam defaults DW_DEF=16, N_DEF=8.
- Sub-module onehot_to_index (parameter N): combinational encoder, outputs idx and valid (popcount==1). It is reused for the check feature.

Test Plan:
All scenarios use N=8, DW=16, RAMP_LOG2=2 (R=4).
- Reset with all inputs nonzero: data_out=0, sel_index=0, busy=0 during and after reset.
- IDLE, ch0=1000, sel=0x01, one sample_en: data_out=1000 one clk later; busy stays 0.
- ch0=1000, ch3=−1000, sel 0x01→0x08, then 4 strobes: data_out 500, 0, −500, −1000. busy=1 from the clk after the change until after the 4th strobe. sel_index changes 0→3 on the 4th strobe.
- Mid-fade to ch3, sel 0x10 then 0x20: the fade to 3 completes, then a fade to 5 starts on the next clk. Ch4 is never targeted. Final sel_index=5.
- IDLE on ch2, sel=0x00 then 0x03 with strobes: output keeps tracking ch2, busy=0. With the macro, onehot_err=1 for each such clk (1-clk delayed).
- reset_n low after the 2nd strobe of a fade: data_out=0, busy=0, sel_index=0 asynchronously. After release, sample_en outputs ch0.
